// File: rtl/pulse_pkg.sv
// Shared definitions for the multi-channel pulse sequencer: channel FSM
// encoding, default SYNC width and small decode/slice helpers.
package pulse_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_P1   = 3'd1;
  localparam logic [2:0] ST_GAP  = 3'd2;
  localparam logic [2:0] ST_P2   = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam int SYNC_W_DEF = 8;

  // Low bit of channel ch inside a flat per-channel field of w bits per channel.
  function automatic int fld_lo(input int ch, input int w);
    return ch * w;
  endfunction

  function automatic logic is_pulse(input logic [2:0] st);
    return (st == ST_P1) || (st == ST_P2);
  endfunction

  function automatic logic is_busy(input logic [2:0] st);
    return (st == ST_P1) || (st == ST_GAP) || (st == ST_P2);
  endfunction

endpackage

// File: rtl/pulse_channel.sv
// One pulse sequencer: P1, gap, P2, then an optional CPMG train of
// (2*del gap, P2) pairs. Zero-length states are skipped within the same edge.
module pulse_channel
  import pulse_pkg::*;
#(
  parameter int CW = 32,
  parameter int NW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_run,
  input  logic          i_start,
  input  logic          i_en,
  input  logic          i_cont,
  input  logic [CW-1:0] i_p1wid,
  input  logic [CW-1:0] i_del,
  input  logic [CW-1:0] i_p2wid,
  input  logic [NW-1:0] i_ncpmg,
  output logic          o_pulse,
  output logic          o_busy_nxt,
  output logic [2:0]    o_state
);

  localparam logic [CW:0] CNT_ONE = {{CW{1'b0}}, 1'b1};

  logic [2:0]    r_state, w_state_nxt;
  logic [CW:0]   r_cnt, w_cnt_nxt;
  logic [NW-1:0] r_k, w_k_nxt;
  logic          r_pulse;
  logic          w_do_p1, w_do_gap1, w_do_p2, w_do_after;

  // r_cnt holds the remaining cycles of the current timed state; the
  // do_* flags chain forward so empty states fall through in one edge.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = (r_cnt != '0) ? r_cnt - 1'b1 : '0;
    w_k_nxt     = r_k;
    w_do_p1     = 1'b0;
    w_do_gap1   = 1'b0;
    w_do_p2     = 1'b0;
    w_do_after  = 1'b0;
    if (!i_run) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
      w_k_nxt     = '0;
    end else if (i_start) begin
      w_k_nxt   = '0;
      w_cnt_nxt = '0;
      if (i_en && !i_cont) w_do_p1 = 1'b1;
      else                 w_state_nxt = ST_IDLE;
    end else if (r_cnt == CNT_ONE) begin
      case (r_state)
        ST_P1:   w_do_gap1  = 1'b1;
        ST_GAP:  w_do_p2    = 1'b1;
        ST_P2:   w_do_after = 1'b1;
        default: ;
      endcase
    end
    if (w_do_p1) begin
      if (i_p1wid != '0) begin
        w_state_nxt = ST_P1;
        w_cnt_nxt   = {1'b0, i_p1wid};
      end else w_do_gap1 = 1'b1;
    end
    if (w_do_gap1) begin
      if (i_del != '0) begin
        w_state_nxt = ST_GAP;
        w_cnt_nxt   = {1'b0, i_del};
      end else w_do_p2 = 1'b1;
    end
    if (w_do_p2) begin
      if (i_p2wid != '0) begin
        w_state_nxt = ST_P2;
        w_cnt_nxt   = {1'b0, i_p2wid};
      end else w_do_after = 1'b1;
    end
    // With both del and p2 zero every remaining CPMG pair is empty.
    if (w_do_after) begin
      w_state_nxt = ST_DONE;
      w_cnt_nxt   = '0;
      if (w_k_nxt < i_ncpmg) begin
        if (i_del != '0) begin
          w_state_nxt = ST_GAP;
          w_cnt_nxt   = {i_del, 1'b0};
          w_k_nxt     = w_k_nxt + 1'b1;
        end else if (i_p2wid != '0) begin
          w_state_nxt = ST_P2;
          w_cnt_nxt   = {1'b0, i_p2wid};
          w_k_nxt     = w_k_nxt + 1'b1;
        end else begin
          w_k_nxt = i_ncpmg;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_k     <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_k     <= w_k_nxt;
      r_pulse <= i_run && (i_cont || is_pulse(w_state_nxt));
    end
  end

  assign o_pulse    = r_pulse;
  assign o_busy_nxt = is_busy(w_state_nxt);
  assign o_state    = r_state;

endmodule

// File: rtl/pulse_seq_multi.sv
// Multi-channel pulse generator: shared period counter, double-buffered
// configuration applied at period boundaries, SYNC strobe and receiver inhibit.
module pulse_seq_multi
  import pulse_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int CW     = 32,
  parameter int NW     = 8,
  parameter int SYNC_W = SYNC_W_DEF
) (
  input  logic               clk_pll,
  input  logic               resetn,
  input  logic               run,
  input  logic               cfg_load,
  input  logic [CW-1:0]      cfg_period,
  input  logic [N_CH*CW-1:0] cfg_p1wid,
  input  logic [N_CH*CW-1:0] cfg_del,
  input  logic [N_CH*CW-1:0] cfg_p2wid,
  input  logic [N_CH*NW-1:0] cfg_ncpmg,
  input  logic [N_CH-1:0]    cfg_en,
  input  logic [N_CH-1:0]    cfg_cont,
  input  logic [15:0]        cfg_blk_off,
  output logic               cfg_pending,
  output logic               sync_on,
  output logic [N_CH-1:0]    pulse_on,
  output logic               inhib,
  output logic [N_CH*3-1:0]  dbg_ch_state
);

  localparam logic [CW-1:0] SYNC_LEN = CW'(SYNC_W);
  localparam logic [CW-1:0] MIN_PER  = CW'(2);

  typedef struct packed {
    logic [N_CH*CW-1:0] p1;
    logic [N_CH*CW-1:0] del;
    logic [N_CH*CW-1:0] p2;
    logic [N_CH*NW-1:0] ncpmg;
    logic [N_CH-1:0]    en;
    logic [N_CH-1:0]    cont;
    logic [15:0]        blk_off;
  } ch_cfg_t;

  ch_cfg_t       r_act, r_pend, w_in, w_eff;
  logic [CW-1:0] r_act_period, r_pend_period, w_period, w_pc_nxt, r_pc;
  logic          r_pending, r_live, r_sync, r_inhib;
  logic [15:0]   r_hold;
  logic          w_wrap, w_start, w_apply;
  logic [N_CH-1:0] w_busy_nxt;

  always_comb begin
    w_in.p1      = cfg_p1wid;
    w_in.del     = cfg_del;
    w_in.p2      = cfg_p2wid;
    w_in.ncpmg   = cfg_ncpmg;
    w_in.en      = cfg_en;
    w_in.cont    = cfg_cont;
    w_in.blk_off = cfg_blk_off;
  end

  // A start is any period boundary: the first cycle after run rises, or a wrap.
  assign w_period = (r_act_period < MIN_PER) ? MIN_PER : r_act_period;
  assign w_wrap   = r_live && (r_pc == w_period - 1'b1);
  assign w_start  = run && (!r_live || w_wrap);
  assign w_apply  = r_pending && (!run || w_start);
  assign w_eff    = w_apply ? r_pend : r_act;
  assign w_pc_nxt = (!run || w_start) ? '0 : r_pc + 1'b1;

  always_ff @(posedge clk_pll or negedge resetn) begin
    if (!resetn) begin
      r_act         <= '0;
      r_pend        <= '0;
      r_act_period  <= '0;
      r_pend_period <= '0;
      r_pending     <= 1'b0;
    end else begin
      if (w_apply) begin
        r_act        <= r_pend;
        r_act_period <= r_pend_period;
      end
      if (cfg_load) begin
        r_pend        <= w_in;
        r_pend_period <= cfg_period;
        r_pending     <= 1'b1;
      end else if (w_apply) begin
        r_pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_pll or negedge resetn) begin
    if (!resetn) begin
      r_pc    <= '0;
      r_live  <= 1'b0;
      r_sync  <= 1'b0;
      r_inhib <= 1'b0;
      r_hold  <= '0;
    end else begin
      r_pc   <= w_pc_nxt;
      r_live <= run;
      r_sync <= run && (w_pc_nxt < SYNC_LEN);
      if (!run) begin
        r_hold  <= '0;
        r_inhib <= 1'b0;
      end else if (|w_busy_nxt) begin
        r_hold  <= w_eff.blk_off;
        r_inhib <= 1'b1;
      end else if (r_hold != '0) begin
        r_hold  <= r_hold - 1'b1;
        r_inhib <= 1'b1;
      end else begin
        r_inhib <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    pulse_channel #(.CW(CW), .NW(NW)) u_ch (
      .i_clk      (clk_pll),
      .i_rst_n    (resetn),
      .i_run      (run),
      .i_start    (w_start),
      .i_en       (w_eff.en[i]),
      .i_cont     (w_eff.cont[i]),
      .i_p1wid    (w_eff.p1[fld_lo(i, CW) +: CW]),
      .i_del      (w_eff.del[fld_lo(i, CW) +: CW]),
      .i_p2wid    (w_eff.p2[fld_lo(i, CW) +: CW]),
      .i_ncpmg    (w_eff.ncpmg[fld_lo(i, NW) +: NW]),
      .o_pulse    (pulse_on[i]),
      .o_busy_nxt (w_busy_nxt[i]),
      .o_state    (dbg_ch_state[fld_lo(i, 3) +: 3])
    );
  end

  assign cfg_pending = r_pending;
  assign sync_on     = r_sync;
  assign inhib       = r_inhib;

endmodule
